// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gcd_job_sequencer
// Purpose  : Queues GCD jobs, feeds them to the GCD core over its shared
//            operand bus and returns results; resolves zero-operand jobs
//            locally and bounds every core run with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_job_sequencer #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH-1:0]       req_a,
    input  logic [WIDTH-1:0]       req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_gcd,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   core_rst,
    output logic                   core_start,
    output logic [WIDTH-1:0]       core_data,
    input  logic                   core_done,
    input  logic [WIDTH-1:0]       core_result
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO   = c_TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_RUN  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t               state_q;
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]     mem_a_q [DEPTH];
    logic [WIDTH-1:0]     mem_b_q [DEPTH];
    logic [WIDTH-1:0]     job_b_q;
    logic [c_TMO_W-1:0]   tmo_q;
    logic [c_TMO_W-1:0]   tmo_d;

    logic                 w_push;
    logic                 w_pop;
    logic [WIDTH-1:0]     w_head_a;
    logic [WIDTH-1:0]     w_head_b;

    // Ready is derived from registered occupancy only, so a same-cycle pop never raises it.
    assign req_ready  = !rst && (count_q < c_DEPTH);
    assign fifo_count = count_q;
    assign w_push     = req_valid && req_ready;
    assign w_pop      = (state_q == S_IDLE) && (count_q != '0);
    assign w_head_a   = mem_a_q[rd_ptr_q];
    assign w_head_b   = mem_b_q[rd_ptr_q];
    assign tmo_d      = (tmo_q == c_TMO) ? tmo_q : tmo_q + c_TMO_W'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_a_q[wr_ptr_q] <= req_a;
            mem_b_q[wr_ptr_q] <= req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            job_b_q    <= '0;
            tmo_q      <= '0;
            res_valid  <= 1'b0;
            res_gcd    <= '0;
            res_err    <= 1'b0;
            core_rst   <= 1'b1;
            core_start <= 1'b0;
            core_data  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    core_rst   <= 1'b1;
                    core_start <= 1'b0;
                    if (w_pop) begin
                        job_b_q <= w_head_b;
                        // The subtractive core never terminates on a zero operand.
                        if ((w_head_a == '0) || (w_head_b == '0)) begin
                            res_gcd   <= w_head_a | w_head_b;
                            res_err   <= (w_head_a == '0) && (w_head_b == '0);
                            res_valid <= 1'b1;
                            state_q   <= S_RESP;
                        end else begin
                            core_rst   <= 1'b0;
                            core_start <= 1'b1;
                            core_data  <= w_head_a;
                            state_q    <= S_LDA;
                        end
                    end
                end
                S_LDA: begin
                    core_start <= 1'b0;
                    core_data  <= job_b_q;
                    state_q    <= S_LDB;
                end
                S_LDB: begin
                    tmo_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    tmo_q <= tmo_d;
                    if (core_done) begin
                        res_gcd   <= core_result;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        core_rst  <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (tmo_d == c_TMO) begin
                        res_gcd   <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        core_rst  <= 1'b1;
                        state_q   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_job_sequencer
// Purpose  : Self-checking bench with a behavioural GCD core and a
//            queue-based response model for gcd_job_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_job_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int NEVER = 255;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_gcd;
    logic        res_err;
    logic [2:0]  fifo_count;
    logic        core_rst;
    logic        core_start;
    logic [15:0] core_data;
    logic        core_done;
    logic [15:0] core_result;

    gcd_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_gcd(res_gcd), .res_err(res_err),
        .fifo_count(fifo_count),
        .core_rst(core_rst), .core_start(core_start), .core_data(core_data),
        .core_done(core_done), .core_result(core_result)
    );

    typedef struct { int g; int e; } exp_t;
    typedef struct { int a; int b; int d; } job_t;

    exp_t exp_q[$];
    job_t nz_q[$];
    int   n_tests, n_fail, start_cnt, resp_cnt, acc_cnt, cyc;
    int   req_dly, cur_a, cur_b, cur_dly;
    bit   ldb_pend, rr_rand, rr_fixed;
    int   cm_st, cm_a, cm_b, cm_cnt, cm_dly;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
        else         res_ready = rr_fixed;
    end

    function automatic int ref_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Behavioural core: A then B on the bus, done a chosen number of cycles later.
    always @(posedge clk) begin
        if (rst || core_rst) begin
            cm_st     <= 0;
            core_done <= 1'b0;
        end else begin
            case (cm_st)
                0: if (core_start) begin cm_a <= int'(core_data); cm_dly <= cur_dly; cm_st <= 1; end
                1: begin cm_b <= int'(core_data); cm_cnt <= 0; cm_st <= 2; end
                2: if (cm_dly != NEVER && cm_cnt == cm_dly) begin
                       core_done   <= 1'b1;
                       core_result <= 16'(ref_gcd(cm_a, cm_b));
                       cm_st       <= 3;
                   end else cm_cnt <= cm_cnt + 1;
                default: ;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        job_t j;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); nz_q.delete(); ldb_pend = 1'b0;
            end else begin
                if (ldb_pend) begin
                    check_eq("bus_b", core_data, cur_b);
                    check_eq("start_one_cycle", core_start, 0);
                    ldb_pend = 1'b0;
                end else if (core_start) begin
                    start_cnt++;
                    if (nz_q.size() == 0) check_eq("start_unexpected", 1, 0);
                    else begin
                        j = nz_q.pop_front();
                        cur_a = j.a; cur_b = j.b; cur_dly = j.d;
                        check_eq("bus_a", core_data, cur_a);
                        check_eq("core_rst_low", core_rst, 0);
                        ldb_pend = 1'b1;
                    end
                end
                if (res_valid && res_ready) begin
                    resp_cnt++;
                    if (exp_q.size() == 0) check_eq("resp_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check_eq("res_gcd", res_gcd, e.g);
                        check_eq("res_err", res_err, e.e);
                        check_eq("core_rst_resp", core_rst, 1);
                    end
                end
                if (req_valid && req_ready) begin
                    acc_cnt++;
                    if (req_a == 0 || req_b == 0) begin
                        e.g = int'(req_a | req_b);
                        e.e = (req_a == 0 && req_b == 0) ? 1 : 0;
                    end else begin
                        j.a = int'(req_a); j.b = int'(req_b); j.d = req_dly;
                        nz_q.push_back(j);
                        // Done becomes visible in RUN cycle dly+2; it must arrive by cycle TMO.
                        if (req_dly + 2 <= TMO) begin e.g = ref_gcd(int'(req_a), int'(req_b)); e.e = 0; end
                        else                    begin e.g = 0; e.e = 1; end
                    end
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic send(input int a, input int b, input int d);
        int  n = 0;
        bit  acc = 1'b0;
        req_a = 16'(a); req_b = 16'(b); req_dly = d; req_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        check_eq("send_accepted", acc, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_count != 0 || res_valid) && n < 3000) begin
            @(negedge clk); n++;
        end
        check_eq("drain_in_time", (n < 3000), 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, a0, t0, n, a, b;
        n_tests = 0; n_fail = 0; start_cnt = 0; resp_cnt = 0; acc_cnt = 0;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_dly = 0;
        rr_rand = 1'b0; rr_fixed = 1'b1; ldb_pend = 1'b0; cur_dly = 0;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_gcd", res_gcd, 0);
        check_eq("rst_res_err", res_err, 0);
        check_eq("rst_core_rst", core_rst, 1);
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_core_data", core_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);

        // Core job (48,18)
        s0 = start_cnt; r0 = resp_cnt;
        send(48, 18, 3);
        @(negedge clk); check_eq("t1_no_early_start", core_start, 0);
        @(negedge clk); check_eq("t1_start", core_start, 1);
        check_eq("t1_bus_a", core_data, 48);
        drain();
        check_eq("t1_start_pulses", start_cnt - s0, 1);
        check_eq("t1_responses", resp_cnt - r0, 1);

        // Zero-operand job (0,35): local result two cycles after acceptance
        s0 = start_cnt;
        send(0, 35, 0);
        @(negedge clk); check_eq("t2_valid_early", res_valid, 0);
        check_eq("t2_core_rst_a", core_rst, 1);
        @(negedge clk); check_eq("t2_valid", res_valid, 1);
        check_eq("t2_gcd", res_gcd, 35);
        check_eq("t2_core_rst_b", core_rst, 1);
        drain();
        check_eq("t2_no_start", start_cnt - s0, 0);

        // (0,0) error then a normal job
        send(0, 0, 0);
        send(21, 14, 2);
        drain();

        // Fill with the response port stalled
        rr_fixed = 1'b0; idle(2);
        a0 = acc_cnt; r0 = resp_cnt;
        for (int i = 0; i < 7; i++) begin
            req_a = 16'(12 * (i + 1)); req_b = 16'(18 * (i + 1)); req_dly = 1; req_valid = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_accepted", acc_cnt - a0, 5);
        check_eq("t4_req_ready", req_ready, 0);
        check_eq("t4_fifo_count", fifo_count, 4);
        rr_fixed = 1'b1;
        drain();
        check_eq("t4_responses", resp_cnt - r0, 5);
        check_eq("t4_fifo_empty", fifo_count, 0);

        // Timeout, done-on-timeout-edge and one-cycle-late cases
        send(9, 6, NEVER);
        n = 0;
        do begin @(negedge clk); n++; end while (!core_start && n < 100);
        check_eq("t5_start_seen", core_start, 1);
        t0 = cyc; n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 100);
        check_eq("t5_run_length", cyc - t0, 18);
        drain();
        send(9, 6, 14); drain();
        send(9, 6, 15); drain();
        send(9, 6, 2);  drain();

        // Reset during RUN with two jobs queued
        s0 = start_cnt; r0 = resp_cnt;
        send(30, 12, NEVER);
        send(5, 10, 1);
        send(7, 21, 1);
        @(negedge clk); check_eq("t6_queued", fifo_count, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("t6_fifo_count", fifo_count, 0);
        check_eq("t6_res_valid", res_valid, 0);
        check_eq("t6_core_rst", core_rst, 1);
        check_eq("t6_core_start", core_start, 0);
        idle(40);
        check_eq("t6_no_response", resp_cnt - r0, 0);
        check_eq("t6_no_restart", start_cnt - s0, 1);

        // Randomised traffic with random downstream backpressure
        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 0 :
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 65535)) : int'($urandom_range(1, 60));
            b = ($urandom_range(0, 5) == 0) ? 0 :
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 65535)) : int'($urandom_range(1, 60));
            send(a, b, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
        end
        drain();
        rr_rand = 1'b0;
        check_eq("final_fifo_count", fifo_count, 0);
        check_eq("final_model_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
